icache_assoc: RTL and testbench

- Parametrised successor instruction cache between IF and the memory controller (MC).
- Set-associative, with configurable block size, set count and way count.
- Stores the full tag per line.
- Round-robin replacement that prefers invalid ways.
- Adds a flush input that squashes in-flight fetch responses and an invalidate-all input for fence.i.

---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_victim_sel.sv | 25 ++
 rtl/icache_assoc.sv | 164 ++++++++++++++++
 tb/tb_icache_assoc.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: FSM encoding
// and the address-split bit positions used by both the IF and MC sides.
package icache_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

    localparam int OFF_LSB = 2;

    function automatic int set_lsb(input int block_width);
        return block_width + OFF_LSB;
    endfunction

    function automatic int tag_lsb(input int set_width, input int block_width);
        return set_width + block_width + OFF_LSB;
    endfunction

endpackage

// File: rtl/icache_victim_sel.sv
// Victim way selection for one set: lowest-index invalid way, otherwise the
// way named by the set's round-robin pointer.
module icache_victim_sel #(
    parameter int WAYS  = 2,
    parameter int IDX_W = 1
) (
    input  logic [WAYS-1:0]  valid_i,
    input  logic [IDX_W-1:0] rr_ptr_i,
    output logic [IDX_W-1:0] victim_o
);

    logic found;

    always_comb begin
        victim_o = rr_ptr_i;
        found    = 1'b0;
        for (int w = 0; w < WAYS; w++) begin
            if (!valid_i[w] && !found) begin
                victim_o = IDX_W'(w);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache between IF and the memory controller,
// with round-robin replacement, fetch squash (flush) and invalidate-all.
module icache_assoc
    import icache_pkg::*;
#(
    parameter int SET_WIDTH   = 3,
    parameter int WAY_WIDTH   = 1,
    parameter int BLOCK_WIDTH = 2,
    parameter int TAG_WIDTH   = 32 - SET_WIDTH - BLOCK_WIDTH - 2
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        rdy_in,
    input  logic                        flush_in,
    input  logic                        inv_all_in,
    input  logic                        IF_query_en,
    input  logic [31:0]                 IF_query_addr,
    output logic                        IF_dout_en,
    output logic [31:0]                 IF_dout,
    output logic                        icache_busy,
    output logic                        MC_query_en,
    output logic [31:0]                 MC_query_addr,
    input  logic                        MC_data_en,
    input  logic [32*(1<<BLOCK_WIDTH)-1:0] MC_data
);

    localparam int SETS       = 1 << SET_WIDTH;
    localparam int WAYS       = 1 << WAY_WIDTH;
    localparam int BLOCK_SIZE = 1 << BLOCK_WIDTH;
    localparam int IDX_W      = (WAY_WIDTH > 0) ? WAY_WIDTH : 1;
    localparam int SET_LSB    = set_lsb(BLOCK_WIDTH);
    localparam int TAG_LSB    = tag_lsb(SET_WIDTH, BLOCK_WIDTH);
    localparam int BLK_W      = 32 * BLOCK_SIZE;

    state_e            state_q;
    logic [31:2]       addr_q;
    logic              squash_q;
    logic              noalloc_q;
    logic [WAYS-1:0]   valid_q [SETS];
    logic [IDX_W-1:0]  rr_q    [SETS];

    logic [TAG_WIDTH-1:0] tag_mem  [SETS][WAYS];
    logic [BLK_W-1:0]     data_mem [SETS][WAYS];

    logic [SET_WIDTH-1:0]   q_set, f_set;
    logic [TAG_WIDTH-1:0]   q_tag, f_tag;
    logic [BLOCK_WIDTH-1:0] q_off, f_off;
    logic [WAYS-1:0]        way_hit;
    logic [BLK_W-1:0]       hit_block;
    logic [31:0]            hit_words  [BLOCK_SIZE];
    logic [31:0]            fill_words [BLOCK_SIZE];
    logic [IDX_W-1:0]       victim;
    logic                   fill_fire, fill_alloc;
    logic                   unused_bits;

    assign unused_bits = ^IF_query_addr[1:0];

    assign q_set = IF_query_addr[SET_LSB +: SET_WIDTH];
    assign q_tag = IF_query_addr[31:TAG_LSB];
    assign q_off = IF_query_addr[OFF_LSB +: BLOCK_WIDTH];
    assign f_set = addr_q[SET_LSB +: SET_WIDTH];
    assign f_tag = addr_q[31:TAG_LSB];
    assign f_off = addr_q[OFF_LSB +: BLOCK_WIDTH];

    assign icache_busy = (state_q == ST_WAIT);

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_hit[gi] = valid_q[q_set][gi] && (tag_mem[q_set][gi] == q_tag);
        end
        for (gi = 0; gi < BLOCK_SIZE; gi++) begin : g_word
            assign hit_words[gi]  = hit_block[gi*32 +: 32];
            assign fill_words[gi] = MC_data[gi*32 +: 32];
        end
    endgenerate

    // At most one way can match, so a priority mux is equivalent to an OR mux.
    always_comb begin
        hit_block = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (way_hit[w]) hit_block = data_mem[q_set][w];
        end
    end

    icache_victim_sel #(
        .WAYS  (WAYS),
        .IDX_W (IDX_W)
    ) u_victim_sel (
        .valid_i  (valid_q[f_set]),
        .rr_ptr_i (rr_q[f_set]),
        .victim_o (victim)
    );

    // An invalidate on the fill edge makes that fill non-allocating as well.
    assign fill_fire  = rdy_in && (state_q == ST_WAIT) && MC_data_en;
    assign fill_alloc = fill_fire && !noalloc_q && !inv_all_in;

    always_ff @(posedge clk_in) begin
        if (fill_alloc) begin
            tag_mem[f_set][victim]  <= f_tag;
            data_mem[f_set][victim] <= MC_data;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q       <= ST_IDLE;
            addr_q        <= '0;
            squash_q      <= 1'b0;
            noalloc_q     <= 1'b0;
            IF_dout_en    <= 1'b0;
            IF_dout       <= '0;
            MC_query_en   <= 1'b0;
            MC_query_addr <= '0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                rr_q[s]    <= '0;
            end
        end else if (rdy_in) begin
            IF_dout_en  <= 1'b0;
            MC_query_en <= 1'b0;
            if (inv_all_in) begin
                for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
            end
            unique case (state_q)
                ST_IDLE: begin
                    if (IF_query_en && !flush_in) begin
                        if (|way_hit) begin
                            IF_dout_en <= 1'b1;
                            IF_dout    <= hit_words[q_off];
                        end else begin
                            addr_q        <= IF_query_addr[31:2];
                            MC_query_en   <= 1'b1;
                            MC_query_addr <= {IF_query_addr[31:SET_LSB], {SET_LSB{1'b0}}};
                            squash_q      <= 1'b0;
                            noalloc_q     <= 1'b0;
                            state_q       <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (flush_in)   squash_q  <= 1'b1;
                    if (inv_all_in) noalloc_q <= 1'b1;
                    if (MC_data_en) begin
                        if (fill_alloc) begin
                            valid_q[f_set][victim] <= 1'b1;
                            rr_q[f_set]            <= rr_q[f_set] + 1'b1;
                        end
                        if (!squash_q && !flush_in) begin
                            IF_dout_en <= 1'b1;
                            IF_dout    <= fill_words[f_off];
                        end
                        squash_q  <= 1'b0;
                        noalloc_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icache_assoc.sv
// Randomised scoreboard bench for icache_assoc with a line-level cache model.
module tb_icache_assoc;

    localparam int SW   = 3;
    localparam int WW   = 1;
    localparam int BW   = 2;
    localparam int SETS = 1 << SW;
    localparam int WAYS = 1 << WW;
    localparam int BS   = 1 << BW;
    localparam int TW   = 32 - SW - BW - 2;

    logic            clk_in = 1'b0;
    logic            rst_n_in, rdy_in, flush_in, inv_all_in, IF_query_en;
    logic [31:0]     IF_query_addr;
    logic            IF_dout_en, icache_busy, MC_query_en;
    logic [31:0]     IF_dout, MC_query_addr;
    logic            MC_data_en;
    logic [32*BS-1:0] MC_data;

    icache_assoc #(.SET_WIDTH(SW), .WAY_WIDTH(WW), .BLOCK_WIDTH(BW)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
        .inv_all_in(inv_all_in), .IF_query_en(IF_query_en), .IF_query_addr(IF_query_addr),
        .IF_dout_en(IF_dout_en), .IF_dout(IF_dout), .icache_busy(icache_busy),
        .MC_query_en(MC_query_en), .MC_query_addr(MC_query_addr),
        .MC_data_en(MC_data_en), .MC_data(MC_data)
    );

    always #5 clk_in = ~clk_in;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit edge_active = 1'b0;

    typedef struct {
        logic [31:0] val;
        int          cyc;
    } exp_t;
    exp_t resp_q[$];
    exp_t mc_q[$];

    // Reference model: which tags each set holds, plus the per-set pointer.
    bit          mvalid [SETS][WAYS];
    logic [TW-1:0] mtag [SETS][WAYS];
    int          mrr    [SETS];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0104) return 32'hDEAD_BEEF;
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    function automatic logic [32*BS-1:0] blk(input logic [31:0] a);
        logic [32*BS-1:0] r;
        logic [31:0] base;
        base = a & ~32'(BS*4 - 1);
        for (int w = 0; w < BS; w++) r[w*32 +: 32] = mem_word(base + 32'(w*4));
        return r;
    endfunction

    function automatic int m_set(input logic [31:0] a);
        return int'((a / (BS*4)) % SETS);
    endfunction

    function automatic logic [TW-1:0] m_tag(input logic [31:0] a);
        return TW'(a / (BS*4*SETS));
    endfunction

    function automatic bit m_hit(input logic [31:0] a);
        for (int w = 0; w < WAYS; w++)
            if (mvalid[m_set(a)][w] && mtag[m_set(a)][w] == m_tag(a)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic void m_fill(input logic [31:0] a);
        int s, v;
        s = m_set(a);
        v = -1;
        for (int w = 0; w < WAYS; w++) if (!mvalid[s][w] && v < 0) v = w;
        if (v < 0) v = mrr[s];
        mvalid[s][v] = 1'b1;
        mtag[s][v]   = m_tag(a);
        mrr[s]       = (mrr[s] + 1) % WAYS;
    endfunction

    function automatic void m_inv_all();
        for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) mvalid[s][w] = 1'b0;
    endfunction

    function automatic void m_reset();
        m_inv_all();
        for (int s = 0; s < SETS; s++) mrr[s] = 0;
    endfunction

    function automatic void push_resp(input logic [31:0] v);
        exp_t e;
        e.val = v;
        e.cyc = cyc + 1;
        resp_q.push_back(e);
    endfunction

    function automatic void push_mc(input logic [31:0] a);
        exp_t e;
        e.val = a & ~32'(BS*4 - 1);
        e.cyc = cyc + 1;
        mc_q.push_back(e);
    endfunction

    always @(posedge clk_in) begin
        cyc         <= cyc + 1;
        edge_active <= rdy_in && rst_n_in;
    end

    // Monitor: each active edge may carry at most one IF and one MC pulse.
    always @(negedge clk_in) begin
        if (edge_active) begin
            if (resp_q.size() > 0 && resp_q[0].cyc <= cyc) begin
                tests++;
                if (!IF_dout_en) begin
                    fails++;
                    $display("FAIL resp_missing cyc=%0d IF_dout_en=0 required 1 (word %h)", cyc, resp_q[0].val);
                end else if (IF_dout !== resp_q[0].val) begin
                    fails++;
                    $display("FAIL resp_data cyc=%0d IF_dout=%h required %h", cyc, IF_dout, resp_q[0].val);
                end else begin
                    $display("[TB] resp cyc=%0d word=%h ok", cyc, IF_dout);
                end
                void'(resp_q.pop_front());
            end else if (IF_dout_en) begin
                tests++;
                fails++;
                $display("FAIL resp_unexpected cyc=%0d IF_dout_en=1 required 0 (IF_dout=%h)", cyc, IF_dout);
            end
            if (mc_q.size() > 0 && mc_q[0].cyc <= cyc) begin
                tests++;
                if (!MC_query_en) begin
                    fails++;
                    $display("FAIL mc_missing cyc=%0d MC_query_en=0 required 1 (addr %h)", cyc, mc_q[0].val);
                end else if (MC_query_addr !== mc_q[0].val) begin
                    fails++;
                    $display("FAIL mc_addr cyc=%0d MC_query_addr=%h required %h", cyc, MC_query_addr, mc_q[0].val);
                end else begin
                    $display("[TB] mc   cyc=%0d addr=%h ok", cyc, MC_query_addr);
                end
                void'(mc_q.pop_front());
            end else if (MC_query_en) begin
                tests++;
                fails++;
                $display("FAIL mc_unexpected cyc=%0d MC_query_en=1 required 0 (addr %h)", cyc, MC_query_addr);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%h required %h", name, got, exp);
        end else begin
            $display("[TB] %s ok (%h)", name, got);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic inv_pulse();
        inv_all_in = 1'b1;
        m_inv_all();
        step();
        inv_all_in = 1'b0;
    endtask

    // One fetch transaction; flush_at/inv_at index the WAIT cycles (-1 = none).
    task automatic fetch(input logic [31:0] a, input bit flush_q, input bit inv_q,
                         input int flush_at, input int inv_at, input int stall);
        bit hit, squash, noalloc;
        int d;
        hit = m_hit(a);
        IF_query_en   = 1'b1;
        IF_query_addr = a;
        flush_in      = flush_q;
        inv_all_in    = inv_q;
        if (!flush_q) begin
            if (hit) push_resp(mem_word(a));
            else     push_mc(a);
        end
        if (inv_q) m_inv_all();
        step();
        IF_query_en = 1'b0;
        flush_in    = 1'b0;
        inv_all_in  = 1'b0;
        if (flush_q || hit) return;
        d = $urandom_range(1, 3);
        if (flush_at >= d) d = flush_at + 1;
        if (inv_at >= d)   d = inv_at + 1;
        squash  = 1'b0;
        noalloc = 1'b0;
        for (int i = 0; i < d; i++) begin
            check("busy_wait", 32'(icache_busy), 32'd1);
            flush_in   = (i == flush_at);
            inv_all_in = (i == inv_at);
            if (i == flush_at) squash = 1'b1;
            if (i == inv_at) begin
                noalloc = 1'b1;
                m_inv_all();
            end
            step();
        end
        flush_in   = 1'b0;
        inv_all_in = 1'b0;
        MC_data_en = 1'b1;
        MC_data    = blk(a);
        if (stall > 0) begin
            rdy_in = 1'b0;
            for (int i = 0; i < stall; i++) begin
                step();
                check("stall_busy", 32'(icache_busy), 32'd1);
                check("stall_no_resp", 32'(IF_dout_en), 32'd0);
            end
            rdy_in = 1'b1;
        end
        if (!noalloc) m_fill(a);
        if (!squash) push_resp(mem_word(a));
        step();
        MC_data_en = 1'b0;
        check("busy_after_fill", 32'(icache_busy), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        rst_n_in = 1'b0; rdy_in = 1'b1; flush_in = 1'b0; inv_all_in = 1'b0;
        IF_query_en = 1'b0; IF_query_addr = '0; MC_data_en = 1'b0; MC_data = '0;
        m_reset();
        #2;
        check("rst_IF_dout_en", 32'(IF_dout_en), 32'd0);
        check("rst_IF_dout", IF_dout, 32'd0);
        check("rst_MC_query_en", 32'(MC_query_en), 32'd0);
        check("rst_MC_query_addr", MC_query_addr, 32'd0);
        check("rst_busy", 32'(icache_busy), 32'd0);
        step(); step();
        rst_n_in = 1'b1;
        step();

        // Cold miss then hit in the same block.
        fetch(32'h0000_0104, 0, 0, -1, -1, 0);
        fetch(32'h0000_0108, 0, 0, -1, -1, 0);

        // Three blocks mapping to set 0 with two ways.
        inv_pulse();
        fetch(32'h0000_0000, 0, 0, -1, -1, 0);
        fetch(32'h0000_0080, 0, 0, -1, -1, 0);
        fetch(32'h0000_0100, 0, 0, -1, -1, 0);
        fetch(32'h0000_0084, 0, 0, -1, -1, 0);
        fetch(32'h0000_0000, 0, 0, -1, -1, 0);

        // Flush one cycle after the launch; line still allocates.
        fetch(32'h0000_0204, 0, 0, 0, -1, 0);
        fetch(32'h0000_0204, 0, 0, -1, -1, 0);

        // Four blocks, invalidate, four misses.
        for (int i = 0; i < 4; i++) fetch(32'h0000_0400 + 32'(i*16), 0, 0, -1, -1, 0);
        inv_pulse();
        for (int i = 0; i < 4; i++) fetch(32'h0000_040C + 32'(i*16), 0, 0, -1, -1, 0);

        // Asynchronous reset during WAIT.
        IF_query_en = 1'b1; IF_query_addr = 32'h0000_0608;
        push_mc(32'h0000_0608);
        step();
        IF_query_en = 1'b0;
        step();
        #2 rst_n_in = 1'b0;
        #1;
        check("async_IF_dout_en", 32'(IF_dout_en), 32'd0);
        check("async_IF_dout", IF_dout, 32'd0);
        check("async_MC_query_en", 32'(MC_query_en), 32'd0);
        check("async_MC_query_addr", MC_query_addr, 32'd0);
        check("async_busy", 32'(icache_busy), 32'd0);
        m_reset();
        step();
        rst_n_in = 1'b1;
        step();
        MC_data_en = 1'b1; MC_data = blk(32'h0000_0608);
        step();
        MC_data_en = 1'b0;
        step();
        check("idle_data_ignored_busy", 32'(icache_busy), 32'd0);
        fetch(32'h0000_0608, 0, 0, -1, -1, 0);

        // rdy_in low for three cycles with MC data pending.
        fetch(32'h0000_0710, 0, 0, -1, -1, 3);
        fetch(32'h0000_0714, 0, 0, -1, -1, 0);

        // Invalidate during WAIT: data returned, line not kept.
        fetch(32'h0000_0520, 0, 0, -1, 0, 0);
        fetch(32'h0000_0520, 0, 0, -1, -1, 0);

        // Flush in IDLE suppresses the hit; hit concurrent with invalidate.
        fetch(32'h0000_0520, 1, 0, -1, -1, 0);
        fetch(32'h0000_0524, 0, 1, -1, -1, 0);
        fetch(32'h0000_0524, 0, 0, -1, -1, 0);

        for (int n = 0; n < 300; n++) begin
            a = (32'($urandom_range(0, 5)) << 7) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2);
            fetch(a, ($urandom_range(0, 15) == 0), ($urandom_range(0, 31) == 0),
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 2)) : -1,
                  ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 2)) : -1,
                  ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0);
            repeat ($urandom_range(0, 2)) step();
        end

        step(); step();
        check("resp_queue_drained", 32'(resp_q.size()), 32'd0);
        check("mc_queue_drained", 32'(mc_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
